lcd_text_refresh: RTL and testbench
===================================

Name: lcd_text_refresh

Overview:
- Downstream stage of the text-generation logic. Consumes two 16-character rows (row_A, row_B) and drives a 16x2 HD44780-compatible character LCD over a 4-bit write-only bus.
- Performs the power-on init sequence once after reset.
- Then refreshes both rows continuously. Each row is snapshotted at the start of every frame, so an upstream row update never tears mid-frame.

Parameters:
- T_PWR, 2000000, idle cycles after reset before the first init nibble (20 ms at 100 MHz).
- T_INIT_NIB, 500000, gap cycles after each of the 4 raw init nibbles (5 ms).
- T_SU, 4, cycles data/RS is valid with E low before E rises.
- T_EH, 24, cycles E is held high.
- T_HOLD, 4, cycles E is low with data held after E falls.
- T_CMD, 4000, gap cycles after every byte except clear (40 us).
- T_CLR, 164000, gap cycles after the clear-display byte 0x01 (1.64 ms).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- row_A  in  128  top-row text; [127:120] is the leftmost character
- row_B  in  128  bottom-row text; same ordering as row_A
- LCD_E  out  1  enable strobe
- LCD_RS  out  1  0 = command, 1 = data
- LCD_RW  out  1  tied to 0 (write only)
- LCD_D  out  4  data nibble
- frame_done  out  1  one-cycle pulse at the end of each full refresh

Behaviour:
- Reset: one clock (clk); reset is synchronous and active-high.
  - While reset is high: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_D=0, frame_done=0, state=PWR_WAIT, counters=0.
  - Reset asserted mid-operation forces E low at the next edge and restarts from PWR_WAIT, including a full re-init.
- Nibble transaction, exactly T_SU+T_EH+T_HOLD cycles:
  - LCD_D and LCD_RS are stable for the whole transaction.
  - E is high for exactly T_EH consecutive cycles.
- Byte transfer:
  - High nibble, then low nibble, back to back with no extra gap.
  - Then a gap of T_CMD cycles, or T_CLR after byte 0x01. During the gap E=0 and D/RS keep their last values.
- State machine:
  - PWR_WAIT: T_PWR cycles.
  - INIT_RAW: nibbles 0x3, 0x3, 0x3, 0x2 with RS=0, each followed by T_INIT_NIB.
  - INIT_CMD: bytes 0x28, 0x0C, 0x06, 0x01 with RS=0.
  - SNAP: latch row_A/row_B into internal copies. Takes 1 cycle.
  - ADDR_A: byte 0x80, RS=0.
  - CHARS_A: 16 bytes from the row_A snapshot with RS=1, index 0..15 selecting bits [127-8i -: 8].
  - ADDR_B: byte 0xC0, RS=0.
  - CHARS_B: 16 bytes from the row_B snapshot, RS=1.
  - FRAME_END: frame_done=1 for 1 cycle, then go to SNAP.
  - Init runs only once per reset; the loop is SNAP..FRAME_END forever.
- Frame length in steady state: 34*(2*(T_SU+T_EH+T_HOLD)+T_CMD)+2 cycles (SNAP + FRAME_END).
- Character index wraps 15 to 0 only via an ADDR state, never beyond 16.
- Row input changes take effect only at the next SNAP. Changes during SNAP are captured with that edge's value.
- Character bytes pass through unfiltered; values 0x00-0xFF are sent verbatim.

Decomposition:
- Package lcd_pkg:
  - state enum.
  - Command constants: FUNC_SET=0x28, DISP_ON=0x0C, ENTRY=0x06, CLEAR=0x01, DDRAM_ROW0=0x80, DDRAM_ROW1=0xC0.
  - Raw init nibble constants.
- Sub-module lcd_nibble_tx:
  - Inputs: start, nib[3:0], rs.
  - Outputs: E/D/RS and a done pulse on the last HOLD cycle.
  - Owns the T_SU/T_EH/T_HOLD counter.
  - The parent FSM owns the gap counter and sequencing.

Test Plan (bench parameters: T_PWR=10, T_INIT_NIB=20, T_SU=1, T_EH=2, T_HOLD=1, T_CMD=5, T_CLR=30):
1. Reset released at cycle 0 -> all outputs 0 through cycle 9; first E rise at cycle 11 with D=0x3, RS=0; E high for exactly 2 cycles.
2. Capture (D,RS) at every E rise through init -> sequence 3,3,3,2, then 2,8,0,C,0,6,0,1, all RS=0. Gap between the last E fall and the next E rise is ≥30 cycles after 0x01 and ≥5 cycles after the other bytes.
3. row_A="Press BTN3 to   ", row_B="show a message.." -> frame decodes to 0x80, 0x50 'P' ... 0x20, 0xC0, 0x73 's' ... 0x2E, with RS=1 only on the 32 characters; LCD_RW=0 throughout.
4. Change row_A to all 0x41 during CHARS_A index 5 -> current frame still sends the old text; the next frame sends 16x 0x41. frame_done pulses once per frame with a period of 34*(2*4+5)+2=444 cycles.
5. Assert reset for 1 cycle while E=1 during CHARS_B -> E=0 on the next edge, frame_done stays 0, and the full PWR_WAIT plus init sequence repeats (scenario 2 values).
6. Across all frames, D and RS are unchanged for every cycle E is high and for T_HOLD after E falls.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared state encodings, HD44780 command bytes and init helpers.
// Revision : 1.0
// ============================================================================
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_PWR_WAIT  = 4'd0,
        ST_INIT_RAW  = 4'd1,
        ST_INIT_CMD  = 4'd2,
        ST_SNAP      = 4'd3,
        ST_ADDR_A    = 4'd4,
        ST_CHARS_A   = 4'd5,
        ST_ADDR_B    = 4'd6,
        ST_CHARS_B   = 4'd7,
        ST_FRAME_END = 4'd8
    } lcd_state_t;

    // Progress of the byte (or raw nibble) currently owned by the sequencer
    typedef enum logic [1:0] {
        PH_HI  = 2'd0,
        PH_LO  = 2'd1,
        PH_GAP = 2'd2
    } lcd_phase_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SU   = 2'd1,
        TX_EH   = 2'd2,
        TX_HOLD = 2'd3
    } tx_phase_t;

    localparam logic [7:0] FUNC_SET   = 8'h28;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] ENTRY      = 8'h06;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] DDRAM_ROW0 = 8'h80;
    localparam logic [7:0] DDRAM_ROW1 = 8'hC0;

    localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [3:0] init_raw_nib(input logic [1:0] idx);
        return (idx == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
    endfunction

    function automatic logic [7:0] init_cmd_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = FUNC_SET;
            2'd1:    b = DISP_ON;
            2'd2:    b = ENTRY;
            default: b = CLEAR;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_nibble_tx.sv
`default_nettype none
// ============================================================================
// Module   : lcd_nibble_tx
// Purpose  : One 4-bit LCD write: setup, E-high, hold; done on last hold cycle.
// Revision : 1.0
// ============================================================================
import lcd_pkg::*;

module lcd_nibble_tx #(
    parameter int unsigned T_SU   = 4,
    parameter int unsigned T_EH   = 24,
    parameter int unsigned T_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] nib,
    input  logic       rs,
    output logic       lcd_e,
    output logic [3:0] lcd_d,
    output logic       lcd_rs,
    output logic       done
);

    localparam int unsigned T_MAX = max2(max2(T_SU, T_EH), T_HOLD);
    localparam int unsigned CW    = $clog2(T_MAX + 1);

    tx_phase_t       phase, phase_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [3:0]      d_n;
    logic            rs_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase  <= TX_IDLE;
            cnt    <= '0;
            lcd_d  <= '0;
            lcd_rs <= 1'b0;
            lcd_e  <= 1'b0;
        end else begin
            phase  <= phase_n;
            cnt    <= cnt_n;
            lcd_d  <= d_n;
            lcd_rs <= rs_n;
            lcd_e  <= (phase_n == TX_EH);
        end
    end

    // A start during the final hold cycle is accepted, giving back-to-back nibbles
    always_comb begin
        phase_n = phase;
        cnt_n   = cnt + CW'(1);
        d_n     = lcd_d;
        rs_n    = lcd_rs;
        case (phase)
            TX_SU: begin
                if (cnt == CW'(T_SU - 1)) begin
                    phase_n = TX_EH;
                    cnt_n   = '0;
                end
            end
            TX_EH: begin
                if (cnt == CW'(T_EH - 1)) begin
                    phase_n = TX_HOLD;
                    cnt_n   = '0;
                end
            end
            TX_HOLD: begin
                if (cnt == CW'(T_HOLD - 1)) begin
                    phase_n = TX_IDLE;
                    cnt_n   = '0;
                end
            end
            default: cnt_n = '0;
        endcase
        if (start) begin
            phase_n = TX_SU;
            cnt_n   = '0;
            d_n     = nib;
            rs_n    = rs;
        end
    end

    assign done = (phase == TX_HOLD) && (cnt == CW'(T_HOLD - 1));

endmodule
`default_nettype wire

// File: rtl/lcd_text_refresh.sv
`default_nettype none
// ============================================================================
// Module   : lcd_text_refresh
// Purpose  : HD44780 4-bit init once, then endless two-row refresh from snapshots.
// Revision : 1.0
// ============================================================================
import lcd_pkg::*;

module lcd_text_refresh #(
    parameter int unsigned T_PWR      = 2000000,
    parameter int unsigned T_INIT_NIB = 500000,
    parameter int unsigned T_SU       = 4,
    parameter int unsigned T_EH       = 24,
    parameter int unsigned T_HOLD     = 4,
    parameter int unsigned T_CMD      = 4000,
    parameter int unsigned T_CLR      = 164000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] row_A,
    input  logic [127:0] row_B,
    output logic         LCD_E,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic [3:0]   LCD_D,
    output logic         frame_done
);

    localparam int unsigned CNT_MAX = max2(max2(T_PWR, T_INIT_NIB), max2(T_CMD, T_CLR));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    lcd_state_t         state, state_n;
    lcd_phase_t         ph, ph_n;
    logic [3:0]         idx, idx_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   gap_last;
    logic [127:0]       snap_a, snap_b;
    logic               start, tx_done, tx_rs;
    logic [3:0]         tx_nib;
    logic [7:0]         cur_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_PWR_WAIT;
            ph     <= PH_HI;
            idx    <= '0;
            cnt    <= '0;
            snap_a <= '0;
            snap_b <= '0;
        end else begin
            state <= state_n;
            ph    <= ph_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            if (state == ST_SNAP) begin
                snap_a <= row_A;
                snap_b <= row_B;
            end
        end
    end

    // Only a command-mode 0x01 is a clear; a 0x01 character gets the normal gap
    always_comb begin
        if (state == ST_INIT_RAW)
            gap_last = CNT_W'(T_INIT_NIB - 1);
        else if ((state == ST_INIT_CMD) && (init_cmd_byte(idx[1:0]) == CLEAR))
            gap_last = CNT_W'(T_CLR - 1);
        else
            gap_last = CNT_W'(T_CMD - 1);
    end

    // The next nibble is launched in the last cycle of the previous step, so no idle cycles
    always_comb begin
        state_n = state;
        ph_n    = ph;
        idx_n   = idx;
        cnt_n   = cnt;
        start   = 1'b0;
        case (state)
            ST_PWR_WAIT: begin
                if (cnt == CNT_W'(T_PWR - 1)) begin
                    state_n = ST_INIT_RAW;
                    ph_n    = PH_HI;
                    idx_n   = '0;
                    cnt_n   = '0;
                    start   = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_SNAP: begin
                state_n = ST_ADDR_A;
                ph_n    = PH_HI;
                idx_n   = '0;
                start   = 1'b1;
            end
            ST_FRAME_END: state_n = ST_SNAP;
            default: begin
                case (ph)
                    PH_HI: begin
                        if (tx_done) begin
                            if (state == ST_INIT_RAW) begin
                                ph_n  = PH_GAP;
                                cnt_n = '0;
                            end else begin
                                ph_n  = PH_LO;
                                start = 1'b1;
                            end
                        end
                    end
                    PH_LO: begin
                        if (tx_done) begin
                            ph_n  = PH_GAP;
                            cnt_n = '0;
                        end
                    end
                    default: begin
                        if (cnt != gap_last) begin
                            cnt_n = cnt + CNT_W'(1);
                        end else begin
                            ph_n  = PH_HI;
                            start = 1'b1;
                            idx_n = idx + 4'd1;
                            case (state)
                                ST_INIT_RAW: begin
                                    if (idx == 4'd3) begin
                                        state_n = ST_INIT_CMD;
                                        idx_n   = '0;
                                    end
                                end
                                ST_INIT_CMD: begin
                                    if (idx == 4'd3) begin
                                        state_n = ST_SNAP;
                                        start   = 1'b0;
                                    end
                                end
                                ST_ADDR_A: begin
                                    state_n = ST_CHARS_A;
                                    idx_n   = '0;
                                end
                                ST_CHARS_A: begin
                                    if (idx == 4'd15) begin
                                        state_n = ST_ADDR_B;
                                        idx_n   = '0;
                                    end
                                end
                                ST_ADDR_B: begin
                                    state_n = ST_CHARS_B;
                                    idx_n   = '0;
                                end
                                ST_CHARS_B: begin
                                    if (idx == 4'd15) begin
                                        state_n = ST_FRAME_END;
                                        start   = 1'b0;
                                    end
                                end
                                default: start = 1'b0;
                            endcase
                        end
                    end
                endcase
            end
        endcase
    end

    // Nibble to launch is selected from the step being entered
    always_comb begin
        cur_byte = 8'h00;
        case (state_n)
            ST_INIT_CMD: cur_byte = init_cmd_byte(idx_n[1:0]);
            ST_ADDR_A:   cur_byte = DDRAM_ROW0;
            ST_CHARS_A:  cur_byte = snap_a[{~idx_n, 3'b000} +: 8];
            ST_ADDR_B:   cur_byte = DDRAM_ROW1;
            ST_CHARS_B:  cur_byte = snap_b[{~idx_n, 3'b000} +: 8];
            default:     cur_byte = 8'h00;
        endcase
        tx_rs = (state_n == ST_CHARS_A) || (state_n == ST_CHARS_B);
        if (state_n == ST_INIT_RAW)
            tx_nib = init_raw_nib(idx_n[1:0]);
        else if (ph_n == PH_LO)
            tx_nib = cur_byte[3:0];
        else
            tx_nib = cur_byte[7:4];
    end

    lcd_nibble_tx #(
        .T_SU   (T_SU),
        .T_EH   (T_EH),
        .T_HOLD (T_HOLD)
    ) u_tx (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .nib    (tx_nib),
        .rs     (tx_rs),
        .lcd_e  (LCD_E),
        .lcd_d  (LCD_D),
        .lcd_rs (LCD_RS),
        .done   (tx_done)
    );

    assign LCD_RW     = 1'b0;
    assign frame_done = (state == ST_FRAME_END);

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_refresh.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_text_refresh
// Purpose  : Directed self-checking bench for lcd_text_refresh with short timings.
// Revision : 1.0
// ============================================================================
module tb_lcd_text_refresh;

    localparam int T_PWR = 10, T_INIT_NIB = 20, T_SU = 1, T_EH = 2, T_HOLD = 1;
    localparam int T_CMD = 5, T_CLR = 30;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] row_A, row_B;
    logic         LCD_E, LCD_RS, LCD_RW, frame_done;
    logic [3:0]   LCD_D;

    typedef struct {
        logic       rs;
        logic [3:0] d;
        int         rise;
        int         fall;
    } nib_t;

    nib_t q[$];
    int   fd_q[$];
    int   cyc = 0, stab_err = 0, eh_err = 0, rw_err = 0, fd_err = 0;
    int   n_checks = 0, n_fail = 0;

    logic [3:0] init_exp [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                  4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
    int         gap_exp  [12] = '{22, 22, 22, 22, 2, 7, 2, 7, 2, 7, 2, 33};
    logic [7:0] a_old [16] = '{8'h50, 8'h72, 8'h65, 8'h73, 8'h73, 8'h20, 8'h42, 8'h54,
                               8'h4E, 8'h33, 8'h20, 8'h74, 8'h6F, 8'h20, 8'h20, 8'h20};
    logic [7:0] b_txt [16] = '{8'h73, 8'h68, 8'h6F, 8'h77, 8'h20, 8'h61, 8'h20, 8'h6D,
                               8'h65, 8'h73, 8'h73, 8'h61, 8'h67, 8'h65, 8'h2E, 8'h2E};

    lcd_text_refresh #(
        .T_PWR(T_PWR), .T_INIT_NIB(T_INIT_NIB), .T_SU(T_SU), .T_EH(T_EH),
        .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_CLR(T_CLR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .row_A      (row_A),
        .row_B      (row_B),
        .LCD_E      (LCD_E),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .LCD_D      (LCD_D),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Bus monitor: logs every E pulse and checks D/RS stability and pulse width
    logic       prev_e = 1'b0, prev_fd = 1'b0;
    logic [4:0] held = '0;
    int         hold_left = 0, eh_len = 0;
    always @(posedge clk) begin
        nib_t n;
        #1;
        if (reset) begin
            cyc = 0; prev_e = 1'b0; prev_fd = 1'b0; hold_left = 0; eh_len = 0;
        end else begin
            cyc++;
            if (LCD_RW !== 1'b0) rw_err++;
            if (LCD_E && !prev_e) begin
                n.rs = LCD_RS; n.d = LCD_D; n.rise = cyc; n.fall = -1;
                q.push_back(n);
                held = {LCD_RS, LCD_D};
                eh_len = 1;
            end else if (LCD_E && prev_e) begin
                eh_len++;
                if ({LCD_RS, LCD_D} !== held) stab_err++;
            end else if (!LCD_E && prev_e) begin
                if (eh_len != T_EH) eh_err++;
                q[q.size()-1].fall = cyc;
                if ({LCD_RS, LCD_D} !== held) stab_err++;
                hold_left = T_HOLD - 1;
            end else if (hold_left > 0) begin
                if ({LCD_RS, LCD_D} !== held) stab_err++;
                hold_left--;
            end
            if (frame_done) begin
                fd_q.push_back(cyc);
                if (prev_fd) fd_err++;
            end
            prev_e  = LCD_E;
            prev_fd = frame_done;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_nibs(input int n, input int budget);
        int k = 0;
        while (q.size() < n && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        if (q.size() < n) begin
            check("timeout_nibbles", q.size(), n);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    endtask

    task automatic check_init(input int base, input string pfx);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("%s_nib%0d", pfx, i), {27'd0, q[base+i].rs, q[base+i].d},
                  {28'd0, init_exp[i]});
            check($sformatf("%s_gap%0d", pfx, i), q[base+i+1].rise - q[base+i].fall, gap_exp[i]);
        end
    endtask

    task automatic check_frame(input int f, input int base, input logic new_a);
        logic [7:0] eb;
        logic       ers;
        for (int j = 0; j < 34; j++) begin
            if (j == 0)       begin eb = 8'h80; ers = 1'b0; end
            else if (j < 17)  begin eb = new_a ? 8'h41 : a_old[j-1]; ers = 1'b1; end
            else if (j == 17) begin eb = 8'hC0; ers = 1'b0; end
            else              begin eb = b_txt[j-18]; ers = 1'b1; end
            check($sformatf("frame%0d_byte%0d", f, j), {q[base+2*j].d, q[base+2*j+1].d}, eb);
            check($sformatf("frame%0d_rs%0d", f, j), {q[base+2*j].rs, q[base+2*j+1].rs}, {ers, ers});
        end
    endtask

    initial begin
        int bad, mark, fd_before;
        row_A = "Press BTN3 to   ";
        row_B = "show a message..";
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", {LCD_E, LCD_RS, LCD_RW, LCD_D, frame_done}, 8'h00);
        @(negedge clk); reset = 1'b0;

        bad = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #2;
            if ({LCD_E, LCD_RS, LCD_RW, LCD_D, frame_done} !== 8'h00) bad++;
        end
        check("pwr_wait_idle", bad, 0);
        @(posedge clk); #2;
        check("setup_d", LCD_D, 4'h3);
        check("setup_e", LCD_E, 1'b0);
        @(posedge clk); #2;
        check("first_rise_e", LCD_E, 1'b1);
        check("first_rise_d_rs", {LCD_RS, LCD_D}, 5'h03);
        @(posedge clk); #2;
        check("first_eh2_e", LCD_E, 1'b1);
        @(posedge clk); #2;
        check("first_hold_e", LCD_E, 1'b0);
        check("first_hold_d", LCD_D, 4'h3);

        // Frame 1, CHARS_A index 5 high nibble: change row_A mid-frame
        wait_nibs(25, 400);
        @(negedge clk); row_A = {16{8'h41}};

        // Frame 3, first CHARS_B high nibble: E has just risen
        wait_nibs(185, 1200);
        check("pre_reset_e", LCD_E, 1'b1);
        check("first_rise_cycle", q[0].rise, 11);
        check_init(0, "init");
        check("frame1_start", q[12].rise, 185);
        check("frame2_start", q[80].rise, 629);
        check_frame(1, 12, 1'b0);
        check_frame(2, 80, 1'b1);
        check("fd_count", fd_q.size(), 2);
        check("fd_first", fd_q[0], 626);
        check("fd_period", fd_q[1] - fd_q[0], 444);

        @(negedge clk); reset = 1'b1;
        mark      = q.size();
        fd_before = fd_q.size();
        @(posedge clk); #2;
        check("reset_e_low", LCD_E, 1'b0);
        check("reset_fd_low", frame_done, 1'b0);
        @(negedge clk); reset = 1'b0;

        wait_nibs(mark + 13, 400);
        check("reinit_first_rise", q[mark].rise, 11);
        check_init(mark, "reinit");
        check("reinit_no_fd", fd_q.size(), fd_before);

        check("dr_stability", stab_err, 0);
        check("e_width", eh_err, 0);
        check("rw_low", rw_err, 0);
        check("fd_single_cycle", fd_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
